logic_unit_arbiter: RTL and testbench



---
 rtl/logic_unit_arbiter_if.sv | 41 ++++
 rtl/logic_unit_arbiter.sv | 108 ++++++++++
 tb/tb_logic_unit_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_unit_arbiter_if.sv
// rtl/logic_unit_arbiter_if.sv - request/response bundle between two requesters and the shared logic unit
interface logic_unit_arbiter_if #(
   parameter int NrOfBits = 32
);
   logic                req0_valid;
   logic                req0_ready;
   logic [NrOfBits-1:0] req0_a;
   logic [NrOfBits-1:0] req0_b;
   logic [2:0]          req0_op;

   logic                req1_valid;
   logic                req1_ready;
   logic [NrOfBits-1:0] req1_a;
   logic [NrOfBits-1:0] req1_b;
   logic [2:0]          req1_op;

   logic                resp_valid;
   logic                resp_ready;
   logic                resp_id;
   logic [NrOfBits-1:0] resp_result;

   // requester/consumer side
   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_op,
      input  req1_ready,
      input  resp_valid, resp_id, resp_result,
      output resp_ready
   );

   // arbiter side
   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_op,
      output req1_ready,
      output resp_valid, resp_id, resp_result,
      input  resp_ready
   );
endinterface

// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - round-robin sharing of one masked NOR logic unit between two requesters
module logic_unit_arbiter #(
   parameter int NrOfBits = 32
) (
   input  logic                Clock,
   input  logic                Reset_n,
   logic_unit_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state;
   state_t              next_state;
   logic                prio;
   logic                grant_id;
   logic                accept;
   logic [NrOfBits-1:0] a_q;
   logic [NrOfBits-1:0] b_q;
   logic [2:0]          op_q;
   logic                id_q;
   logic [NrOfBits-1:0] gate_out;

   // grant: a lone valid requester wins, a tie is broken by prio only
   always_comb begin
      grant_id = (bus.req0_valid & bus.req1_valid) ? prio : bus.req1_valid;
      accept   = (state == IDLE) & (bus.req0_valid | bus.req1_valid);
   end

   // bubble-masked NOR: op[0]/op[1] invert the inputs, op[2] inverts the output
   always_comb begin
      gate_out = {NrOfBits{op_q[2]}} ^
                 ~((a_q ^ {NrOfBits{op_q[0]}}) | (b_q ^ {NrOfBits{op_q[1]}}));
   end

   // state register
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // next-state: one transaction in flight, response held until consumed
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = EXEC;
         EXEC:    next_state = RESP;
         RESP:    if (bus.resp_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // handshake outputs: ready only for the granted requester while idle
   always_comb begin
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
      bus.resp_valid = 1'b0;
      if (state == IDLE) begin
         bus.req0_ready = bus.req0_valid & ~grant_id;
         bus.req1_ready = bus.req1_valid & grant_id;
      end
      if (state == RESP) begin
         bus.resp_valid = 1'b1;
      end
   end

   // operand capture from the granted requester on accept
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         a_q  <= '0;
         b_q  <= '0;
         op_q <= 3'b000;
         id_q <= 1'b0;
      end else if (accept) begin
         a_q  <= grant_id ? bus.req1_a  : bus.req0_a;
         b_q  <= grant_id ? bus.req1_b  : bus.req0_b;
         op_q <= grant_id ? bus.req1_op : bus.req0_op;
         id_q <= grant_id;
      end
   end

   // result register: loads only on the EXEC to RESP edge so it never follows request inputs
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         bus.resp_result <= '0;
         bus.resp_id     <= 1'b0;
      end else if (state == EXEC) begin
         bus.resp_result <= gate_out;
         bus.resp_id     <= id_q;
      end
   end

   // round-robin pointer: after a completed response the other requester wins ties
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         prio <= 1'b0;
      end else if ((state == RESP) && bus.resp_ready) begin
         prio <= ~bus.resp_id;
      end
   end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - randomized and directed self-checking bench for logic_unit_arbiter
module tb_logic_unit_arbiter;
   localparam int NrOfBits = 8;
   typedef logic [NrOfBits-1:0] word_t;

   logic Clock   = 1'b0;
   logic Reset_n = 1'b0;
   int   checks  = 0;
   int   errors  = 0;
   int   cyc     = 0;

   always #5 Clock = ~Clock;
   always @(posedge Clock) cyc <= cyc + 1;

   logic_unit_arbiter_if #(.NrOfBits(NrOfBits)) bus ();
   logic_unit_arbiter #(.NrOfBits(NrOfBits)) dut (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // function table written out per operation name
   function automatic word_t model_fn(input word_t a, input word_t b, input logic [2:0] op);
      case (op)
         3'b000:  return ~(a | b);
         3'b011:  return a & b;
         3'b001:  return a & ~b;
         3'b010:  return ~a & b;
         3'b100:  return a | b;
         3'b111:  return ~(a & b);
         3'b101:  return ~a | b;
         default: return a | ~b;
      endcase
   endfunction

   // reference model: one job in flight, visible two cycles after accept, ties go to m_prio
   bit    m_busy = 1'b0;
   int    m_due  = 0;
   bit    m_id   = 1'b0;
   word_t m_res  = '0;
   bit    m_prio = 1'b0;

   always @(negedge Clock) begin
      bit e0, e1, ev;
      if (!Reset_n) begin
         m_busy = 1'b0;
         m_prio = 1'b0;
         check("reset resp_valid", 32'(bus.resp_valid), 0);
         check("reset resp_id", 32'(bus.resp_id), 0);
         check("reset resp_result", 32'(bus.resp_result), 0);
      end else begin
         e0 = 1'b0;
         e1 = 1'b0;
         if (!m_busy) begin
            if (bus.req0_valid && bus.req1_valid) begin
               e0 = !m_prio;
               e1 = m_prio;
            end else begin
               e0 = bus.req0_valid;
               e1 = bus.req1_valid;
            end
         end
         ev = m_busy && (cyc >= m_due);
         check("model req0_ready", 32'(bus.req0_ready), 32'(e0));
         check("model req1_ready", 32'(bus.req1_ready), 32'(e1));
         check("model resp_valid", 32'(bus.resp_valid), 32'(ev));
         if (ev) begin
            check("model resp_id", 32'(bus.resp_id), 32'(m_id));
            check("model resp_result", 32'(bus.resp_result), 32'(m_res));
         end
         if (e0 || e1) begin
            m_busy = 1'b1;
            m_due  = cyc + 2;
            m_id   = e1;
            m_res  = e1 ? model_fn(bus.req1_a, bus.req1_b, bus.req1_op)
                        : model_fn(bus.req0_a, bus.req0_b, bus.req0_op);
         end else if (ev && bus.resp_ready) begin
            m_busy = 1'b0;
            m_prio = !m_id;
         end
      end
   end

   task automatic drive_req(input bit id, input bit v, input word_t a, input word_t b,
                            input logic [2:0] op);
      if (id) begin
         bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
      end else begin
         bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
      end
   endtask

   task automatic drive_rand(input bit id);
      drive_req(id, 1'b1, word_t'($urandom), word_t'($urandom), 3'($urandom_range(7)));
   endtask

   function automatic bit rdy(input bit id);
      return id ? bus.req1_ready : bus.req0_ready;
   endfunction

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // one transaction from an idle arbiter with resp_ready=1 and literal result
   task automatic single(input bit id, input word_t a, input word_t b, input logic [2:0] op,
                         input word_t exp, input string name);
      int  n;
      int  t_acc;
      bit  got;
      t_acc = 0;
      drive_req(id, 1'b1, a, b, op);
      got = 1'b0;
      for (n = 0; n < 20 && !got; n++) begin
         @(negedge Clock);
         if (rdy(id)) begin got = 1'b1; t_acc = cyc; end
      end
      check({name, " accepted"}, 32'(got), 1);
      check({name, " accept wait"}, n, 1);
      tick();
      drive_req(id, 1'b0, a, b, op);
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge Clock);
         if (bus.resp_valid) got = 1'b1;
      end
      check({name, " resp seen"}, 32'(got), 1);
      check({name, " latency"}, cyc - t_acc, 2);
      check({name, " result"}, 32'(bus.resp_result), 32'(exp));
      check({name, " id"}, 32'(bus.resp_id), 32'(id));
      tick();
   endtask

   // accept a job, then pull reset low in EXEC between clock edges
   task automatic reset_in_exec(input bit id, input word_t a, input word_t b, input logic [2:0] op);
      bit got;
      drive_req(id, 1'b1, a, b, op);
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge Clock);
         if (rdy(id)) got = 1'b1;
      end
      check("abort accepted", 32'(got), 1);
      tick();
      drive_req(id, 1'b0, a, b, op);
      #2 Reset_n = 1'b0;
      #1;
      check("abort resp_valid", 32'(bus.resp_valid), 0);
      check("abort resp_result", 32'(bus.resp_result), 0);
      check("abort resp_id", 32'(bus.resp_id), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int  order[4];
      int  t_acc[3];
      int  k;
      bit  acc0, acc1;
      word_t cap_res;
      bit    cap_id;
      bit    got;

      drive_req(0, 1'b0, '0, '0, 3'b000);
      drive_req(1, 1'b0, '0, '0, 3'b000);
      bus.resp_ready = 1'b1;
      repeat (3) @(posedge Clock);
      #1 Reset_n = 1'b1;

      single(0, 8'hF0, 8'h0C, 3'b000, 8'h03, "nor req0");
      single(1, 8'hF0, 8'h3C, 3'b011, 8'h30, "and req1");
      single(1, 8'hF0, 8'h3C, 3'b001, 8'hC0, "andn req1");
      single(1, 8'hF0, 8'h3C, 3'b100, 8'hFC, "or req1");
      single(1, 8'hF0, 8'h3C, 3'b111, 8'hCF, "nand req1");

      reset_in_exec(1, 8'h12, 8'h34, 3'b100);
      repeat (2) @(posedge Clock);
      #1 Reset_n = 1'b1;

      single(0, 8'hA5, 8'h0F, 3'b100, 8'hAF, "or req0");
      reset_in_exec(0, 8'h5A, 8'hFF, 3'b011);

      // both requesters valid from reset release: grants must alternate starting at 0
      drive_rand(0);
      drive_rand(1);
      repeat (2) @(posedge Clock);
      #1 Reset_n = 1'b1;
      k = 0;
      for (int n = 0; n < 40 && k < 4; n++) begin
         @(negedge Clock);
         acc0 = bus.req0_ready;
         acc1 = bus.req1_ready;
         if (acc0) begin order[k] = 0; k++; end
         else if (acc1) begin order[k] = 1; k++; end
         tick();
         if (acc0) drive_rand(0);
         if (acc1) drive_rand(1);
      end
      check("rr grant count", k, 4);
      for (int i = 0; i < 4; i++) check("rr grant order", order[i], i % 2);
      drive_req(0, 1'b0, '0, '0, 3'b000);
      drive_req(1, 1'b0, '0, '0, 3'b000);
      repeat (4) tick();

      // backpressure: response held five cycles while req0 waits
      bus.resp_ready = 1'b0;
      drive_req(0, 1'b1, 8'hF0, 8'h0C, 3'b110);
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge Clock);
         if (bus.req0_ready) got = 1'b1;
      end
      check("bp accepted", 32'(got), 1);
      tick();
      drive_rand(0);
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge Clock);
         if (bus.resp_valid) got = 1'b1;
      end
      check("bp resp seen", 32'(got), 1);
      cap_res = bus.resp_result;
      cap_id  = bus.resp_id;
      check("bp result", 32'(cap_res), 32'h0000_00F3);
      check("bp id", 32'(cap_id), 0);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge Clock);
         check("bp resp_valid held", 32'(bus.resp_valid), 1);
         check("bp result stable", 32'(bus.resp_result), 32'(cap_res));
         check("bp id stable", 32'(bus.resp_id), 32'(cap_id));
         check("bp req0_ready low", 32'(bus.req0_ready), 0);
         tick();
      end
      bus.resp_ready = 1'b1;
      @(negedge Clock);
      check("bp handshake cycle ready", 32'(bus.req0_ready), 0);
      tick();
      @(negedge Clock);
      check("bp accept after handshake", 32'(bus.req0_ready), 1);
      tick();
      drive_req(0, 1'b0, '0, '0, 3'b000);
      repeat (4) tick();

      // single requester back-to-back: accepts exactly 3 cycles apart
      drive_rand(1);
      k = 0;
      for (int n = 0; n < 40 && k < 3; n++) begin
         @(negedge Clock);
         acc1 = bus.req1_ready;
         if (acc1) begin t_acc[k] = cyc; k++; end
         tick();
         if (acc1) drive_rand(1);
      end
      check("b2b accept count", k, 3);
      check("b2b spacing 1", t_acc[1] - t_acc[0], 3);
      check("b2b spacing 2", t_acc[2] - t_acc[1], 3);
      drive_req(1, 1'b0, '0, '0, 3'b000);
      repeat (4) tick();

      // random traffic against the model
      for (int c = 0; c < 400; c++) begin
         @(negedge Clock);
         acc0 = bus.req0_valid & bus.req0_ready;
         acc1 = bus.req1_valid & bus.req1_ready;
         tick();
         bus.resp_ready = ($urandom_range(3) != 0);
         if (bus.req0_valid) begin
            if (acc0) begin
               if ($urandom_range(1) != 0) drive_rand(0);
               else bus.req0_valid = 1'b0;
            end else if ($urandom_range(7) == 0) begin
               bus.req0_valid = 1'b0;
            end
         end else if ($urandom_range(2) == 0) begin
            drive_rand(0);
         end
         if (bus.req1_valid) begin
            if (acc1) begin
               if ($urandom_range(1) != 0) drive_rand(1);
               else bus.req1_valid = 1'b0;
            end else if ($urandom_range(7) == 0) begin
               bus.req1_valid = 1'b0;
            end
         end else if ($urandom_range(2) == 0) begin
            drive_rand(1);
         end
      end
      drive_req(0, 1'b0, '0, '0, 3'b000);
      drive_req(1, 1'b0, '0, '0, 3'b000);
      bus.resp_ready = 1'b1;
      repeat (5) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
